// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory target for a processor data port. A request is
// accepted over a valid/ready channel, held for a fixed number of wait states,
// then the access is performed against a word-organised RAM. The result is
// offered on a valid/ready response channel. Loads support byte/half/word
// sizing with sign or zero extension. Stores merge only the addressed byte
// lanes. Misaligned, illegal-size and out-of-range accesses are reported as
// errors and never modify the RAM.
//
// Parameters
//   DEPTH_WORDS  RAM depth in 32-bit words
//   LATENCY      wait cycles between acceptance and response (1..15)
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-high reset (clears RAM, FSM to IDLE)
//   req_valid     request present
//   req_ready     target can accept a request (IDLE only)
//   req_write     1 = store, 0 = load
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   rsp_valid     response present (RESP only)
//   rsp_ready     initiator accepts response
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_error     access faulted
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;

    // Latched request and wait counter
    logic [3:0]  count_reg;
    logic        write_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;

    // Registered response
    logic [31:0] rdata_reg;
    logic        error_reg;

    logic [31:0] ram_reg [DEPTH_WORDS];

    // Decode of the latched request
    logic        accept;
    logic        access_now;
    logic        commit;
    logic [29:0] word_idx;
    logic [1:0]  lane;
    logic        in_range;
    logic        access_error;
    logic [31:0] rd_word;
    logic [3:0]  byte_en;
    logic [31:0] wlanes;
    logic [31:0] merged;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    assign accept     = (state_reg == IDLE) && req_valid;
    assign access_now = (state_reg == WAIT) && (count_reg == 4'd0);
    assign word_idx   = addr_reg[31:2];
    assign lane       = addr_reg[1:0];
    assign in_range   = ({2'b00, word_idx} < 32'(DEPTH_WORDS));
    assign commit     = access_now && write_reg && !access_error;

    // Read the addressed word only when it exists; out-of-range reads are
    // errors anyway and must not index past the array.
    assign rd_word = in_range ? ram_reg[word_idx[IDX_W-1:0]] : 32'd0;

    always_comb begin
        access_error = 1'b0;
        if (size_reg == 2'b11)                          access_error = 1'b1;
        if (size_reg == 2'b01 && lane[0])               access_error = 1'b1;
        if (size_reg == 2'b10 && lane != 2'b00)         access_error = 1'b1;
        if (!in_range)                                  access_error = 1'b1;
    end

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        byte_en = 4'b0000;
        wlanes  = wdata_reg;
        case (size_reg)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wlanes  = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wlanes  = {2{wdata_reg[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wlanes  = wdata_reg;
            end
            default: begin
                byte_en = 4'b0000;
                wlanes  = wdata_reg;
            end
        endcase
    end

    // Read-modify-write merge: untouched lanes keep the old word contents
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged[8*gi +: 8] = byte_en[gi] ? wlanes[8*gi +: 8] : rd_word[8*gi +: 8];
    end

    // Load extraction and extension
    always_comb begin
        sel_byte  = rd_word[{lane, 3'b000} +: 8];
        sel_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (size_reg)
            2'b00:   load_data = {{24{~uns_reg & sel_byte[7]}}, sel_byte};
            2'b01:   load_data = {{16{~uns_reg & sel_half[15]}}, sel_half};
            default: load_data = rd_word;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = WAIT;
            WAIT:    if (count_reg == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs. req_ready is masked by reset so it stays low throughout
    // reset, including before the state register has been initialised.
    always_comb begin
        req_ready = (state_reg == IDLE) && !reset;
        rsp_valid = (state_reg == RESP);
        rsp_rdata = rdata_reg;
        rsp_error = error_reg;
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= 4'd0;
            write_reg <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            size_reg  <= 2'b00;
            uns_reg   <= 1'b0;
            rdata_reg <= 32'd0;
            error_reg <= 1'b0;
        end else begin
            if (accept) begin
                write_reg <= req_write;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                size_reg  <= req_size;
                uns_reg   <= req_unsigned;
                count_reg <= 4'(LATENCY - 1);
            end else if (state_reg == WAIT && count_reg != 4'd0) begin
                count_reg <= count_reg - 4'd1;
            end
            if (access_now) begin
                rdata_reg <= (access_error || write_reg) ? 32'd0 : load_data;
                error_reg <= access_error;
            end
        end
    end

    // RAM: cleared by reset, written on the WAIT->RESP edge of a good store
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                ram_reg[i] <= 32'd0;
            end
        end else if (commit) begin
            ram_reg[word_idx[IDX_W-1:0]] <= merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. The driver pushes the hand-computed
// expected response of each request into a queue; an independent monitor
// pops and compares whenever a response handshake occurs.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;

    always #5 clock = ~clock;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a response transfers at the posedge following a negedge where
    // both valid and ready are high.
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, required no response",
                         rsp_rdata, rsp_error);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e[31:0]);
                check("rsp_error", {31'd0, rsp_error}, {31'd0, mon_e[32]});
                $display("rsp: rdata=0x%08h err=%0b (expected 0x%08h err=%0b)",
                         rsp_rdata, rsp_error, mon_e[31:0], mon_e[32]);
            end
        end
    end

    // One complete transaction. With hold set, rsp_ready is kept low for five
    // cycles of RESP while stability and non-acceptance are checked.
    task automatic issue(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] sz, input logic u,
                         input logic [31:0] er, input logic ee, input bit hold);
        int n;
        if (hold) rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_addr     = a;
        req_wdata    = d;
        req_size     = sz;
        req_unsigned = u;
        exp_q.push_back({ee, er});
        @(posedge clock); #1;
        // Scramble the request inputs; they must be ignored after acceptance
        req_valid    = 1'b0;
        req_write    = ~w;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = ~sz;
        req_unsigned = ~u;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_latency"}, n, LAT);
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
                check({tag, "_hold_rdata"}, rsp_rdata, er);
                check({tag, "_hold_error"}, {31'd0, rsp_error}, {31'd0, ee});
                check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
                if (c == 2) begin
                    req_valid = 1'b1;
                    req_write = 1'b1;
                    req_addr  = 32'h30;
                    req_wdata = 32'h55AA55AA;
                    req_size  = 2'b10;
                end
                @(posedge clock); #1;
                req_valid = 1'b0;
            end
            rsp_ready = 1'b1;
            @(posedge clock); #1;
            check({tag, "_release_valid"}, {31'd0, rsp_valid}, 32'd0);
            check({tag, "_release_req_ready"}, {31'd0, req_ready}, 32'd1);
        end else begin
            n = 0;
            while (rsp_valid && n < 20) begin
                @(posedge clock); #1;
                n++;
            end
            check({tag, "_resp_cycles"}, n, 1);
        end
        $display("txn %s: %s addr=0x%08h wdata=0x%08h size=%0d uns=%0b -> expect 0x%08h err=%0b",
                 tag, w ? "ST" : "LD", a, d, sz, u, er, ee);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Word store/load
        issue("SW10",  1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0);
        issue("LW10",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        // Byte store merges into the top lane
        issue("SB13",  1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0);
        issue("LB13",  1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0);
        issue("LBU13", 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0, 1'b0);
        issue("LW10b", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 1'b0);
        issue("LHU12", 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 32'h000080AD, 1'b0, 1'b0);
        issue("LH12",  1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'hFFFF80AD, 1'b0, 1'b0);
        issue("LB10",  1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hFFFFFFEF, 1'b0, 1'b0);
        issue("LHU10", 1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 32'h0000BEEF, 1'b0, 1'b0);
        // Half store to upper lane pair
        issue("SH16",  1'b1, 32'h16, 32'h1234ABCD, 2'b01, 1'b0, 32'h0,        1'b0, 1'b0);
        issue("LW14",  1'b0, 32'h14, 32'h0,        2'b10, 1'b0, 32'hABCD0000, 1'b0, 1'b0);
        // Misaligned and illegal accesses
        issue("LH11",  1'b0, 32'h11, 32'h0,        2'b01, 1'b0, 32'h0,        1'b1, 1'b0);
        issue("SW12",  1'b1, 32'h12, 32'h12345678, 2'b10, 1'b0, 32'h0,        1'b1, 1'b0);
        issue("LW10c", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 1'b0);
        issue("ILL",   1'b0, 32'h10, 32'h0,        2'b11, 1'b0, 32'h0,        1'b1, 1'b0);
        // Range boundary
        issue("LW400", 1'b0, 32'h400, 32'h0,       2'b10, 1'b0, 32'h0,        1'b1, 1'b0);
        issue("LW3FC", 1'b0, 32'h3FC, 32'h0,       2'b10, 1'b0, 32'h0,        1'b0, 1'b0);
        // Backpressure with a rejected request pulse during RESP
        issue("BP",    1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 1'b1);
        issue("LW30",  1'b0, 32'h30, 32'h0,        2'b10, 1'b0, 32'h0,        1'b0, 1'b0);

        // Reset during WAIT abandons a store
        begin : rst_in_wait
            int n;
            n = 0;
            while (!req_ready && n < 20) begin
                @(posedge clock); #1;
                n++;
            end
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'h20;
            req_wdata = 32'hCAFEF00D;
            req_size  = 2'b10;
            @(posedge clock); #1;
            req_valid = 1'b0;
            reset     = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(posedge clock); #1;
                check("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                check("rst_wait_req_ready", {31'd0, req_ready}, 32'd0);
            end
            reset = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clock); #1;
                check("after_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            end
            $display("txn RSTWAIT: ST addr=0x00000020 abandoned by reset");
        end
        issue("LW20",  1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h0,        1'b0, 1'b0);
        issue("LW10r", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h0,        1'b0, 1'b0);

        repeat (3) @(posedge clock);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory target that answers load/store requests from the processor's data-memory port over a valid/ready request channel and a valid/ready response channel. It holds a word-organised RAM, applies byte/half/word sizing with sign or zero extension on loads and byte-lane merging on stores, and inserts a fixed number of wait states. It flags misaligned, illegal-size and out-of-range accesses, so the core can be evaluated against a realistic, non-zero-latency memory.

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words.
- LATENCY, 2: wait cycles between request acceptance and response; legal range 1..15.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  target can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  32  load data, extended to 32 bits; 0 for stores and errors.
- rsp_error  out  1  access faulted.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1, latch write, addr, wdata, size and unsigned. Load the wait counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready=0, rsp_valid=0. Each edge decrements the counter. On the edge where the counter is 0, perform the access and go to RESP.
- RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_error hold steady until an edge with rsp_ready=1, which returns the FSM to IDLE. No overlap: a new request is accepted only in IDLE.
- Word index = addr[31:2]; lane = addr[1:0].
- Error if any of the following holds: size=11; size=01 and addr[0]=1; size=10 and addr[1:0]!=0; word index >= DEPTH_WORDS.
- On error: no RAM write, rsp_rdata=0, rsp_error=1.
- Load: select the byte at lane or the half at lane[1]. Sign- or zero-extend per unsigned. A word load returns the word unchanged.
- Store: replace only the addressed byte lanes with the low bytes of wdata; the other lanes keep their old contents. rsp_rdata=0.
- Reset: all RAM words cleared to 0; FSM to IDLE.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_error=0, counter=0.
  - req_ready=0 while reset is high; it becomes 1 in the first cycle after reset deasserts.
- Acceptance at edge E0: rsp_valid goes high after edge E0+LATENCY.
  - LATENCY=2: WAIT occupies cycles E0→E1 and E1→E2; rsp_valid is visible after E2.
- RAM write commits at edge E0+LATENCY, the WAIT→RESP edge. A load issued afterwards sees the new data.
- Minimum request-to-request spacing is LATENCY+2 cycles when rsp_ready is held high.
- Request inputs are ignored outside IDLE; changes after acceptance have no effect.
- rsp_ready is ignored outside RESP.
- If rsp_ready is already high when RESP is entered, the response completes at the next edge (one-cycle RESP).
- Reset in any state takes effect at the next edge and abandons the transaction: a pending store is not committed and no response is issued.
- Counter is 4 bits wide and never wraps: it is loaded only on acceptance.

## Test plan
- Reset, SW 0xDEADBEEF at 0x10, then LW 0x10 with LATENCY=2 and rsp_ready=1 → rsp_valid after the second edge post-acceptance, rdata=0xDEADBEEF, error=0.
- SB wdata=0x80 at 0x13, then:
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LW 0x10 → 0x80ADBEEF.
  - LHU 0x12 → 0x000080AD.
- Misaligned and illegal accesses:
  - LH 0x11 → error=1, rdata=0.
  - SW 0x12 with 0x12345678 → error=1; LW 0x10 still returns 0x80ADBEEF.
  - size=11 → error=1.
- Out of range with DEPTH_WORDS=256: LW 0x400 → error=1, rdata=0; LW 0x3FC → error=0, data 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rdata and error stay stable and req_ready=0. A req_valid pulse at that time is not accepted. Raising rsp_ready → IDLE next edge and req_ready=1.
- Reset asserted during WAIT of SW 0xCAFEF00D at 0x20 → rsp_valid never rises. After release, LW 0x20 → 0x00000000.
